// File: rtl/tt_sweep_collector_if.sv
// Control/result bundle between a sweep requester and tt_sweep_collector.
//   master : drives start/expected_tt, observes busy/done/tt/match
//   slave  : the collector itself
// Optional macro TT_POPCOUNT_EN adds ones_count (count of 1s in tt).
interface tt_sweep_collector_if #(
   parameter int NIN = 7
);
   localparam int TTW = 1 << NIN;

   logic           start;
   logic [TTW-1:0] expected_tt;
   logic           busy;
   logic           done;
   logic [TTW-1:0] tt;
   logic           match;
`ifdef TT_POPCOUNT_EN
   logic [NIN:0]   ones_count;

   modport master (output start, expected_tt,
                   input  busy, done, tt, match, ones_count);
   modport slave  (input  start, expected_tt,
                   output busy, done, tt, match, ones_count);
`else
   modport master (output start, expected_tt,
                   input  busy, done, tt, match);
   modport slave  (input  start, expected_tt,
                   output busy, done, tt, match);
`endif
endinterface

// File: rtl/tt_sweep_collector.sv
// Truth-table sweep collector: drives every pattern x = 0..2^NIN-1 into a
// combinational function-under-test, samples its output after LAT cycles,
// assembles the truth table (bit i = f(x=i)) and compares it against an
// expected table latched at start.
//
// Ports:
//   i_clk   : clock, all state on rising edge
//   i_rst   : synchronous active-high reset
//   bus     : tt_sweep_collector_if.slave (start, expected_tt, busy, done,
//             tt, match [, ones_count])
//   o_x     : pattern driven to the FUT (registered)
//   i_f_in  : FUT output
// Optional macro TT_POPCOUNT_EN: enables ones_count on the bus.
//
// state | meaning
// IDLE  | waiting for start; tt/match hold last result
// SWEEP | driving x = 0..TTW-1, one pattern per cycle
// DRAIN | LAT cycles letting the delay line empty
// FIN   | one cycle; table complete, raises done and computes match
module tt_sweep_collector #(
   parameter int NIN = 7,
   parameter int LAT = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   tt_sweep_collector_if.slave   bus,
   output logic [NIN-1:0]        o_x,
   input  logic                  i_f_in
);
   localparam int TTW = 1 << NIN;
   localparam logic [NIN-1:0] X_LAST   = {NIN{1'b1}};
   localparam logic [2:0]     DRAIN_LD = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

   typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN, S_FIN} state_t;

   state_t         r_state;
   logic [NIN-1:0] r_x;
   logic           r_busy;
   logic           r_done;
   logic           r_match;
   logic [TTW-1:0] r_tt;
   logic [TTW-1:0] r_exp;
   logic [2:0]     r_drain_cnt;
`ifdef TT_POPCOUNT_EN
   logic [NIN:0]   r_ones;
`endif

   logic           w_push;
   logic           w_smp_vld;
   logic [NIN-1:0] w_smp_idx;

   assign w_push = (r_state == S_SWEEP);

   // Delay line carries (valid, idx) so the sample lands on the pattern that
   // produced it, LAT cycles after x was driven.
   generate
      if (LAT == 0) begin : g_nodelay
         assign w_smp_vld = w_push;
         assign w_smp_idx = r_x;
      end else begin : g_delay
         logic [LAT-1:0] r_dl_vld;
         logic [NIN-1:0] r_dl_idx [LAT];

         always_ff @(posedge i_clk) begin
            if (i_rst) begin
               r_dl_vld <= '0;
               for (int i = 0; i < LAT; i++) r_dl_idx[i] <= '0;
            end else begin
               r_dl_vld[0] <= w_push;
               r_dl_idx[0] <= r_x;
               for (int i = 1; i < LAT; i++) begin
                  r_dl_vld[i] <= r_dl_vld[i-1];
                  r_dl_idx[i] <= r_dl_idx[i-1];
               end
            end
         end

         assign w_smp_vld = r_dl_vld[LAT-1];
         assign w_smp_idx = r_dl_idx[LAT-1];
      end
   endgenerate

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= S_IDLE;
         r_x         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_match     <= 1'b0;
         r_tt        <= '0;
         r_exp       <= '0;
         r_drain_cnt <= '0;
`ifdef TT_POPCOUNT_EN
         r_ones      <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         if (w_smp_vld) r_tt[w_smp_idx] <= i_f_in;
`ifdef TT_POPCOUNT_EN
         if (w_smp_vld && i_f_in) r_ones <= r_ones + 1'b1;
`endif
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_state <= S_SWEEP;
                  r_tt    <= '0;
                  r_match <= 1'b0;
                  r_exp   <= bus.expected_tt;
                  r_x     <= '0;
                  r_busy  <= 1'b1;
`ifdef TT_POPCOUNT_EN
                  r_ones  <= '0;
`endif
               end
            end
            S_SWEEP: begin
               // x parks on the last pattern instead of wrapping
               if (r_x == X_LAST) begin
                  if (LAT > 0) begin
                     r_state     <= S_DRAIN;
                     r_drain_cnt <= DRAIN_LD;
                  end else begin
                     r_state <= S_FIN;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_x <= r_x + 1'b1;
               end
            end
            S_DRAIN: begin
               if (r_drain_cnt == 3'd0) begin
                  r_state <= S_FIN;
                  r_busy  <= 1'b0;
               end else begin
                  r_drain_cnt <= r_drain_cnt - 3'd1;
               end
            end
            S_FIN: begin
               r_done  <= 1'b1;
               r_match <= (r_tt == r_exp);
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_x        = r_x;
   assign bus.busy   = r_busy;
   assign bus.done   = r_done;
   assign bus.tt     = r_tt;
   assign bus.match  = r_match;
`ifdef TT_POPCOUNT_EN
   assign bus.ones_count = r_ones;
`endif

endmodule

// File: tb/tb_tt_sweep_collector.sv
// Directed bench for tt_sweep_collector: one instance with LAT=0 and one
// with LAT=2, each fed by a bench-side function-under-test.
module tb_tt_sweep_collector;
   logic clk = 1'b0;
   logic rst;

   tt_sweep_collector_if #(.NIN(7)) bus0();
   tt_sweep_collector_if #(.NIN(7)) bus2();

   logic [6:0]   x0, x2;
   logic         f0, f2;
   logic         d1, d2;
   int           mode0;
   logic [127:0] maj_rom;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // FUT for the LAT=0 instance: 0 = tied low, 1 = x[0], 2 = majority-network table
   always_comb begin
      f0 = 1'b0;
      case (mode0)
         1:       f0 = x0[0];
         2:       f0 = maj_rom[x0];
         default: f0 = 1'b0;
      endcase
   end

   // FUT for the LAT=2 instance: x[6] delayed two cycles
   always @(posedge clk) begin
      d1 <= x2[6];
      d2 <= d1;
   end
   assign f2 = d2;

   tt_sweep_collector #(.NIN(7), .LAT(0)) u_dut0 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus0.slave),
      .o_x   (x0),
      .i_f_in(f0)
   );

   tt_sweep_collector #(.NIN(7), .LAT(2)) u_dut2 (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus2.slave),
      .o_x   (x2),
      .i_f_in(f2)
   );

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Counts edges after the start edge until done is seen; optionally pokes
   // start on bus0 at a given cycle to prove it is ignored while busy.
   task automatic wait_done(input bit sel2, input int poke_at,
                            output int lat, output int busy_cyc);
      logic dn, bz;
      lat = 0;
      busy_cyc = 0;
      dn = 1'b0;
      while (lat < 400) begin
         dn = sel2 ? bus2.done : bus0.done;
         bz = sel2 ? bus2.busy : bus0.busy;
         if (bz) busy_cyc++;
         if (dn) break;
         if (poke_at >= 0 && lat == poke_at) bus0.start = 1'b1;
         else if (poke_at >= 0 && lat == poke_at + 1) bus0.start = 1'b0;
         tick();
         lat++;
      end
      if (!dn) chk("done_timeout", dn, 1'b1);
   endtask

   task automatic start_and_wait(input bit sel2, input logic [127:0] e,
                                 input int poke_at, input bit hold,
                                 output int lat, output int busy_cyc);
      if (sel2) begin
         bus2.expected_tt = e;
         bus2.start = 1'b1;
      end else begin
         bus0.expected_tt = e;
         bus0.start = 1'b1;
      end
      tick();
      if (!hold) begin
         bus0.start = 1'b0;
         bus2.start = 1'b0;
      end
      wait_done(sel2, poke_at, lat, busy_cyc);
   endtask

   initial begin
      int lat, bc, ndone;
      maj_rom = 128'hfeeaeee8fce8e8c0fce8e8c0e888a880;
      mode0 = 0;
      bus0.start = 1'b0; bus0.expected_tt = '0;
      bus2.start = 1'b0; bus2.expected_tt = '0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      chk("rst_x",     x0,         7'd0);
      chk("rst_busy",  bus0.busy,  1'b0);
      chk("rst_done",  bus0.done,  1'b0);
      chk("rst_tt",    bus0.tt,    128'd0);
      chk("rst_match", bus0.match, 1'b0);
      chk("rst_tt2",   bus2.tt,    128'd0);

      // f tied 0, expected 0
      start_and_wait(1'b0, 128'd0, -1, 1'b0, lat, bc);
      chk("zero_lat",   lat,        129);
      chk("zero_busy",  bc,         128);
      chk("zero_tt",    bus0.tt,    128'd0);
      chk("zero_match", bus0.match, 1'b1);
      chk("zero_xhold", x0,         7'd127);
      tick();
      chk("done_pulse", bus0.done,  1'b0);
      chk("match_hold", bus0.match, 1'b1);

      // f = x[0]
      mode0 = 1;
      start_and_wait(1'b0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, -1, 1'b0, lat, bc);
      chk("x0_lat",   lat,        129);
      chk("x0_tt",    bus0.tt,    128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      chk("x0_match", bus0.match, 1'b1);
`ifdef TT_POPCOUNT_EN
      chk("x0_ones",  bus0.ones_count, 8'd64);
`endif

      // LAT=2, f = x[6] delayed, deliberately wrong expected
      start_and_wait(1'b1, 128'd0, -1, 1'b0, lat, bc);
      chk("l2_lat",   lat,        131);
      chk("l2_busy",  bc,         130);
      chk("l2_tt",    bus2.tt,    128'hFFFFFFFFFFFFFFFF0000000000000000);
      chk("l2_match", bus2.match, 1'b0);
      chk("l2_xhold", x2,         7'd127);
`ifdef TT_POPCOUNT_EN
      chk("l2_ones",  bus2.ones_count, 8'd64);
`endif

      // majority-network table
      mode0 = 2;
      start_and_wait(1'b0, 128'hfeeaeee8fce8e8c0fce8e8c0e888a880, -1, 1'b0, lat, bc);
      chk("maj_tt",    bus0.tt,    128'hfeeaeee8fce8e8c0fce8e8c0e888a880);
      chk("maj_match", bus0.match, 1'b1);
`ifdef TT_POPCOUNT_EN
      chk("maj_ones",  bus0.ones_count, 8'd64);
`endif

      // reset at sweep cycle 50
      mode0 = 1;
      bus0.expected_tt = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
      bus0.start = 1'b1;
      tick();
      bus0.start = 1'b0;
      repeat (50) tick();
      chk("mid_busy_pre", bus0.busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_busy",  bus0.busy,  1'b0);
      chk("mid_tt",    bus0.tt,    128'd0);
      chk("mid_x",     x0,         7'd0);
      chk("mid_match", bus0.match, 1'b0);
      ndone = 0;
      for (int i = 0; i < 200; i++) begin
         if (bus0.done) ndone++;
         tick();
      end
      chk("mid_nodone", ndone, 0);
      start_and_wait(1'b0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, -1, 1'b0, lat, bc);
      chk("mid_re_lat",   lat,        129);
      chk("mid_re_tt",    bus0.tt,    128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      chk("mid_re_match", bus0.match, 1'b1);

      // start pulsed again while busy is ignored
      start_and_wait(1'b0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, 10, 1'b0, lat, bc);
      chk("poke_lat", lat,     129);
      chk("poke_tt",  bus0.tt, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      tick();
      chk("poke_idle", bus0.busy, 1'b0);

      // start held high: back-to-back sweeps with one IDLE cycle
      start_and_wait(1'b0, 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA, -1, 1'b1, lat, bc);
      chk("hold_lat",   lat,       129);
      chk("hold_idle",  bus0.busy, 1'b0);
      tick();
      bus0.start = 1'b0;
      chk("hold_rebusy", bus0.busy,  1'b1);
      chk("hold_redone", bus0.done,  1'b0);
      chk("hold_rematch", bus0.match, 1'b0);
      wait_done(1'b0, -1, lat, bc);
      chk("hold2_lat",   lat,        129);
      chk("hold2_tt",    bus0.tt,    128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA);
      chk("hold2_match", bus0.match, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
